// File: rtl/rvvi_serial_pkg.sv
// Shared widths and helpers for the RVVI retire serializer.
// Imported by the interface, the compactor and the top level.
package rvvi_serial_pkg;

   localparam int ORDER_W    = 64;
   localparam int TRAP_W     = 1;
   localparam int DROP_CNT_W = 32;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int entry_w(
      input int nhart,
      input int retire,
      input int ilen,
      input int xlen
   );
      return idx_w(nhart) + idx_w(retire)
           + ilen + xlen + TRAP_W + ORDER_W;
   endfunction

endpackage

// File: rtl/rvvi_retire_serializer_if.sv
// Output stream of the serializer: one retired event per beat.
// The serializer drives master; the sampler takes slave.
interface rvvi_retire_serializer_if #(
   parameter int ILEN   = 32,
   parameter int XLEN   = 64,
   parameter int NHART  = 1,
   parameter int RETIRE = 1
) ();
   import rvvi_serial_pkg::*;

   localparam int HW = idx_w(NHART);
   localparam int SW = idx_w(RETIRE);

   logic               out_valid;
   logic               out_ready;
   logic [HW-1:0]      out_hart;
   logic [SW-1:0]      out_slot;
   logic [ILEN-1:0]    out_insn;
   logic [XLEN-1:0]    out_pc;
   logic               out_trap;
   logic [ORDER_W-1:0] out_order;

   modport master (
      output out_valid,
      output out_hart,
      output out_slot,
      output out_insn,
      output out_pc,
      output out_trap,
      output out_order,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_hart,
      input  out_slot,
      input  out_insn,
      input  out_pc,
      input  out_trap,
      input  out_order,
      output out_ready
   );

endinterface

// File: rtl/retire_compactor.sv
// Prefix-sum write offsets and fit mask for the flattened slots.
// Purely combinational; slots past the free space do not fit.
module retire_compactor
   import rvvi_serial_pkg::*;
#(
   parameter int NS = 1,
   parameter int AW = 1,
   parameter int CW = 2
) (
   input  logic [NS-1:0]         valid,
   input  logic [CW-1:0]         free,
   output logic [NS-1:0][AW-1:0] offset,
   output logic [NS-1:0]         fits,
   output logic [CW-1:0]         n_valid,
   output logic [CW-1:0]         n_wr
);

   always_comb begin
      logic [CW-1:0] acc;
      logic [CW-1:0] wr;
      acc    = '0;
      wr     = '0;
      offset = '0;
      fits   = '0;
      for (int i = 0; i < NS; i++) begin
         offset[i] = acc[AW-1:0];
         fits[i]   = valid[i] && (acc < free);
         acc       = acc + CW'(valid[i]);
         wr        = wr + CW'(fits[i]);
      end
      n_valid = acc;
      n_wr    = wr;
   end

endmodule

// File: rtl/rvvi_retire_serializer.sv
// Captures every valid RVVI retire slot into a circular FIFO and
// streams them one per cycle; flags order gaps and counts drops.
module rvvi_retire_serializer
   import rvvi_serial_pkg::*;
#(
   parameter int ILEN   = 32,
   parameter int XLEN   = 64,
   parameter int NHART  = 1,
   parameter int RETIRE = 1,
   parameter int DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NHART-1:0][RETIRE-1:0] valid,
   input  logic [NHART-1:0][RETIRE-1:0][ILEN-1:0] insn,
   input  logic [NHART-1:0][RETIRE-1:0][XLEN-1:0] pc,
   input  logic [NHART-1:0][RETIRE-1:0] trap,
   input  logic [NHART-1:0][RETIRE-1:0][ORDER_W-1:0] order,
   rvvi_retire_serializer_if.master  stream,
   output logic                      overflow,
   output logic [DROP_CNT_W-1:0]     drop_count,
   output logic [NHART-1:0]          order_err
);

   localparam int NS = NHART * RETIRE;
   localparam int AW = idx_w(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = idx_w(NHART);
   localparam int SW = idx_w(RETIRE);
   localparam int EW = entry_w(NHART, RETIRE, ILEN, XLEN);

   logic [EW-1:0]         mem [DEPTH];
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         free;
   logic [NS-1:0]         flat_valid;
   logic [NS-1:0][EW-1:0] flat_entry;
   logic [NS-1:0][AW-1:0] offset;
   logic [NS-1:0]         fits;
   logic [CW-1:0]         n_valid;
   logic [CW-1:0]         n_wr;
   logic [CW-1:0]         n_drop;
   logic                  deq;

   logic [NHART-1:0]              seen, seen_n;
   logic [NHART-1:0][ORDER_W-1:0] expected, exp_n;
   logic [NHART-1:0]              err_n;
   logic [DROP_CNT_W:0]           drop_sum;
   logic [DROP_CNT_W-1:0]         drop_next;

   for (genvar h = 0; h < NHART; h++) begin : g_h
      for (genvar s = 0; s < RETIRE; s++) begin : g_s
         localparam int I = h * RETIRE + s;
         assign flat_valid[I] = valid[h][s];
         assign flat_entry[I] = {
            HW'(h), SW'(s), insn[h][s],
            pc[h][s], trap[h][s], order[h][s]
         };
      end
   end

   // Space is judged before this cycle's dequeue frees anything.
   assign free = CW'(DEPTH) - count;

   retire_compactor #(
      .NS (NS),
      .AW (AW),
      .CW (CW)
   ) u_cmp (
      .valid   (flat_valid),
      .free    (free),
      .offset  (offset),
      .fits    (fits),
      .n_valid (n_valid),
      .n_wr    (n_wr)
   );

   assign n_drop = n_valid - n_wr;

   assign stream.out_valid = (count != '0);
   assign deq = stream.out_valid && stream.out_ready;

   assign {stream.out_hart, stream.out_slot,
           stream.out_insn, stream.out_pc,
           stream.out_trap, stream.out_order} =
      stream.out_valid ? mem[rptr] : '0;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (fits[i]) begin
            mem[wptr + offset[i]] <= flat_entry[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + n_wr[AW-1:0];
         rptr  <= rptr + AW'(deq);
         count <= count + n_wr - CW'(deq);
      end
   end

   // Dropped slots still take part in the order check.
   always_comb begin
      seen_n = seen;
      exp_n  = expected;
      err_n  = order_err;
      for (int h = 0; h < NHART; h++) begin
         for (int s = 0; s < RETIRE; s++) begin
            if (valid[h][s]) begin
               if (seen_n[h] && (order[h][s] != exp_n[h])) begin
                  err_n[h] = 1'b1;
               end
               exp_n[h]  = order[h][s] + ORDER_W'(1);
               seen_n[h] = 1'b1;
            end
         end
      end
   end

   assign drop_sum  = {1'b0, drop_count}
                    + (DROP_CNT_W + 1)'(n_drop);
   assign drop_next = drop_sum[DROP_CNT_W] ? '1
                    : drop_sum[DROP_CNT_W-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
         order_err  <= '0;
         seen       <= '0;
         expected   <= '0;
      end else begin
         overflow   <= overflow | (n_drop != '0);
         drop_count <= drop_next;
         order_err  <= err_n;
         seen       <= seen_n;
         expected   <= exp_n;
      end
   end

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// Bench for rvvi_retire_serializer: 2 harts x 2 slots, depth 4,
// vector table plus scoreboard and hand-built reset/order sequences.
module tb_rvvi_retire_serializer;
   import rvvi_serial_pkg::*;

   localparam int NH  = 2;
   localparam int NR  = 2;
   localparam int DEP = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [NH-1:0][NR-1:0]        valid;
   logic [NH-1:0][NR-1:0][31:0]  insn;
   logic [NH-1:0][NR-1:0][63:0]  pc;
   logic [NH-1:0][NR-1:0]        trap;
   logic [NH-1:0][NR-1:0][63:0]  order;
   logic                         overflow;
   logic [31:0]                  drop_count;
   logic [NH-1:0]                order_err;

   rvvi_retire_serializer_if #(
      .ILEN(32), .XLEN(64), .NHART(NH), .RETIRE(NR)
   ) s_if ();

   rvvi_retire_serializer #(
      .ILEN(32), .XLEN(64), .NHART(NH), .RETIRE(NR), .DEPTH(DEP)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .valid      (valid),
      .insn       (insn),
      .pc         (pc),
      .trap       (trap),
      .order      (order),
      .stream     (s_if),
      .overflow   (overflow),
      .drop_count (drop_count),
      .order_err  (order_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [0:0]  hart;
      logic [0:0]  slot;
      logic [31:0] insn;
      logic [63:0] pc;
      logic        trap;
      logic [63:0] order;
   } ev_t;

   typedef struct {
      logic [3:0]  mask;
      logic        rdy;
      logic [31:0] drop;
   } vec_t;

   ev_t  q[$];
   vec_t tbl[17];
   int   checks = 0;
   int   errors = 0;
   int   seq = 0;
   logic [63:0] ord_next [NH];

   logic          m_ovf;
   logic [31:0]   m_drop;
   logic [NH-1:0] m_err;
   logic [NH-1:0] m_seen;
   logic [63:0]   m_exp [NH];

   task automatic chk(input string name,
                      input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_ovf  = 1'b0;
      m_drop = '0;
      m_err  = '0;
      m_seen = '0;
      for (int h = 0; h < NH; h++) m_exp[h] = '0;
   endtask

   task automatic set_slots(input logic [3:0] m);
      for (int i = 0; i < 4; i++) begin
         automatic int h = i / 2;
         automatic int s = i % 2;
         valid[h][s] = m[i];
         if (m[i]) begin
            pc[h][s]    = 64'h8000_0000 + 64'(4 * seq);
            insn[h][s]  = 32'h0000_0013 | (32'(seq) << 7);
            trap[h][s]  = (seq % 3 == 2);
            order[h][s] = ord_next[h];
            ord_next[h] = ord_next[h] + 1;
            seq++;
         end else begin
            pc[h][s]    = '0;
            insn[h][s]  = '0;
            trap[h][s]  = 1'b0;
            order[h][s] = '0;
         end
      end
   endtask

   function automatic ev_t head_now();
      return {s_if.out_hart, s_if.out_slot, s_if.out_insn,
              s_if.out_pc, s_if.out_trap, s_if.out_order};
   endfunction

   task automatic cycle();
      int free, wr, dr;
      ev_t ev;
      @(negedge clk);
      chk("out_valid", s_if.out_valid, q.size() != 0);
      if (q.size() != 0) chk("head", head_now(), q[0]);
      else chk("head_zero", head_now(), '0);
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_drop);
      chk("order_err", order_err, m_err);
      free = DEP - q.size();
      if (q.size() != 0 && s_if.out_ready) void'(q.pop_front());
      wr = 0;
      dr = 0;
      for (int i = 0; i < 4; i++) begin
         automatic int h = i / 2;
         automatic int s = i % 2;
         if (valid[h][s]) begin
            ev = {1'(h), 1'(s), insn[h][s], pc[h][s],
                  trap[h][s], order[h][s]};
            if (wr < free) begin
               q.push_back(ev);
               wr++;
            end else begin
               dr++;
            end
            if (m_seen[h] && order[h][s] != m_exp[h]) m_err[h] = 1'b1;
            m_exp[h]  = order[h][s] + 1;
            m_seen[h] = 1'b1;
         end
      end
      if (dr > 0) m_ovf = 1'b1;
      if (64'(m_drop) + 64'(dr) > 64'h0000_0000_FFFF_FFFF) m_drop = '1;
      else m_drop = m_drop + 32'(dr);
      @(posedge clk);
      #1;
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_out_valid", s_if.out_valid, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_drop", drop_count, 32'd0);
      chk("rst_order_err", order_err, 2'b00);
      chk("rst_head_zero", head_now(), '0);
      model_clear();
      set_slots(4'b0000);
      s_if.out_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{4'b0001, 1'b1, 32'd0};
      tbl[1]  = '{4'b0001, 1'b1, 32'd0};
      tbl[2]  = '{4'b0000, 1'b1, 32'd0};
      tbl[3]  = '{4'b1111, 1'b1, 32'd0};
      tbl[4]  = '{4'b0000, 1'b1, 32'd0};
      tbl[5]  = '{4'b0000, 1'b1, 32'd0};
      tbl[6]  = '{4'b0000, 1'b1, 32'd0};
      tbl[7]  = '{4'b0000, 1'b1, 32'd0};
      tbl[8]  = '{4'b1111, 1'b0, 32'd0};
      tbl[9]  = '{4'b1111, 1'b0, 32'd4};
      tbl[10] = '{4'b1111, 1'b1, 32'd8};
      tbl[11] = '{4'b1111, 1'b0, 32'd11};
      tbl[12] = '{4'b0101, 1'b1, 32'd13};
      tbl[13] = '{4'b0000, 1'b1, 32'd13};
      tbl[14] = '{4'b0000, 1'b1, 32'd13};
      tbl[15] = '{4'b0000, 1'b1, 32'd13};
      tbl[16] = '{4'b0000, 1'b1, 32'd13};

      for (int h = 0; h < NH; h++) ord_next[h] = '0;
      model_clear();
      set_slots(4'b0000);
      s_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", s_if.out_valid, 1'b0);
      chk("reset_head", head_now(), '0);
      chk("reset_overflow", overflow, 1'b0);
      chk("reset_drop", drop_count, 32'd0);
      chk("reset_order_err", order_err, 2'b00);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         set_slots(tbl[i].mask);
         s_if.out_ready = tbl[i].rdy;
         cycle();
         chk($sformatf("tbl%0d_drop", i), drop_count, tbl[i].drop);
      end
      chk("tbl_overflow", overflow, 1'b1);

      async_reset();
      s_if.out_ready = 1'b1;
      ord_next[1] = 64'd10;
      set_slots(4'b0100);
      cycle();
      ord_next[1] = 64'd12;
      set_slots(4'b0100);
      cycle();
      chk("gap_err", order_err, 2'b10);
      set_slots(4'b0100);
      cycle();
      chk("gap_sticky", order_err, 2'b10);

      s_if.out_ready = 1'b0;
      set_slots(4'b1111);
      cycle();
      chk("fill_drop", drop_count, 32'd1);
      s_if.out_ready = 1'b1;
      set_slots(4'b0000);
      cycle();
      set_slots(4'b1111);
      async_reset();

      s_if.out_ready = 1'b1;
      ord_next[1] = 64'd100;
      set_slots(4'b0100);
      cycle();
      chk("post_rst_first", order_err, 2'b00);
      set_slots(4'b0100);
      cycle();
      set_slots(4'b0000);
      cycle();
      cycle();
      chk("post_rst_err", order_err, 2'b00);
      chk("post_rst_empty", s_if.out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
